// File: rtl/time_nmr_lock_end.sv
// time_nmr_lock_end
//
// Output end of the time-redundant execution path. Every operation arrives
// NumCopies times in a row with the same ID. This block gathers those copies,
// compares them (NumCopies=2) or majority-votes them (NumCopies=3), and emits
// one result per group with a needs_retry flag for the downstream retry stage.
// While a group is partially collected, lock_o holds the upstream round-robin
// arbiter on the current opgroup so that all copies leave through it.
// A partial group that sees no further copies for LockTimeout cycles is
// flushed as untrustworthy and the lock is released.
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   enable_i          1: redundancy active, 0: every input passes straight out
//   data_i, id_i      incoming result copy and its operation ID
//   valid_i, ready_o  upstream handshake
//   lock_o            keep the arbiter grant while a partial group is open
//   data_o, id_o      emitted (voted) result and its ID
//   needs_retry_o     emitted result cannot be trusted
//   valid_o, ready_i  downstream handshake
//   fault_detected_o  one-cycle pulse alongside any faulty emission
//
// Handshake: a transfer happens on a clock edge where valid and ready are both
// high. Once valid_o is raised, valid_o/data_o/id_o/needs_retry_o stay frozen
// until ready_i is seen high; ready_o = !valid_o || ready_i, so the output
// register acts as a single skid-free pipeline stage.
module time_nmr_lock_end #(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned NumCopies   = 2,
  parameter int unsigned IDSize      = 4,
  parameter int unsigned LockTimeout = 5,
  localparam int unsigned TimeoutWidth = $clog2(LockTimeout + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic [IDSize-1:0]    id_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 lock_o,
  output logic [DataWidth-1:0] data_o,
  output logic [IDSize-1:0]    id_o,
  output logic                 needs_retry_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 fault_detected_o
);

  localparam int unsigned CntWidth = $clog2(NumCopies);
  localparam int          BufDepth = NumCopies - 1;
  localparam logic [CntWidth-1:0]     LastCount  = CntWidth'(NumCopies - 1);
  localparam logic [TimeoutWidth-1:0] TimeoutMax = TimeoutWidth'(LockTimeout);

  if (!(NumCopies == 2 || NumCopies == 3)) begin : g_bad_copies
    $error("time_nmr_lock_end: NumCopies must be 2 or 3");
  end
  if (LockTimeout < 1) begin : g_bad_timeout
    $error("time_nmr_lock_end: LockTimeout must be at least 1");
  end

  // Buffered copies of the open group; all share buf_id.
  logic [DataWidth-1:0]    buf_data [BufDepth];
  logic [IDSize-1:0]       buf_id;
  logic [CntWidth-1:0]     count;
  logic [TimeoutWidth-1:0] tmo_cnt;

  logic                 valid_q, retry_q, fault_q;
  logic [DataWidth-1:0] data_q;
  logic [IDSize-1:0]    id_q;

  logic accept, group_open, id_match, tmo_expired;
  logic do_store, do_complete, do_lost, do_flush, do_pass, load_out;
  logic [DataWidth-1:0] nxt_data;
  logic [IDSize-1:0]    nxt_id;
  logic                 nxt_retry, nxt_fault;

  logic [DataWidth-1:0] vote_data;
  logic                 vote_retry, vote_fault;

  assign ready_o     = !valid_q || ready_i;
  assign accept      = valid_i && ready_o;
  assign group_open  = (count != '0);
  assign id_match    = (id_i == buf_id);
  assign tmo_expired = (tmo_cnt == TimeoutMax);
  assign lock_o      = enable_i && group_open && (tmo_cnt < TimeoutMax);

  // Voting: the incoming copy is always the last member of the group.
  if (NumCopies == 2) begin : g_dmr
    assign vote_data  = buf_data[0];
    assign vote_retry = (buf_data[0] != data_i);
    assign vote_fault = vote_retry;
  end else begin : g_tmr
    logic eq01, eq02, eq12;
    assign eq01 = (buf_data[0] == buf_data[1]);
    assign eq02 = (buf_data[0] == data_i);
    assign eq12 = (buf_data[1] == data_i);
    // With no majority the first copy is forwarded and a retry is requested.
    assign vote_data  = (eq01 || eq02) ? buf_data[0] : (eq12 ? buf_data[1] : buf_data[0]);
    assign vote_retry = !(eq01 || eq02 || eq12);
    assign vote_fault = !(eq01 && eq02);
  end

  // Action decode. An accepted copy always takes priority over a timeout.
  always_comb begin
    do_store    = 1'b0;
    do_complete = 1'b0;
    do_lost     = 1'b0;
    do_flush    = 1'b0;
    do_pass     = 1'b0;
    if (!enable_i) begin
      do_pass = accept;
    end else if (accept) begin
      if (!group_open)            do_store    = 1'b1;
      else if (!id_match)         do_lost     = 1'b1;
      else if (count == LastCount) do_complete = 1'b1;
      else                        do_store    = 1'b1;
    end else if (group_open && tmo_expired && ready_o) begin
      do_flush = 1'b1;
    end
  end

  always_comb begin
    load_out  = do_pass || do_complete || do_lost || do_flush;
    nxt_data  = data_i;
    nxt_id    = id_i;
    nxt_retry = 1'b0;
    nxt_fault = 1'b0;
    if (do_complete) begin
      nxt_data  = vote_data;
      nxt_id    = buf_id;
      nxt_retry = vote_retry;
      nxt_fault = vote_fault;
    end else if (do_lost || do_flush) begin
      // Incomplete group: report the first copy under the buffered ID.
      nxt_data  = buf_data[0];
      nxt_id    = buf_id;
      nxt_retry = 1'b1;
      nxt_fault = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BufDepth; i++) buf_data[i] <= '0;
      buf_id  <= '0;
      count   <= '0;
      tmo_cnt <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      retry_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= nxt_fault;

      if (load_out) begin
        valid_q <= 1'b1;
        data_q  <= nxt_data;
        id_q    <= nxt_id;
        retry_q <= nxt_retry;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end

      if (!enable_i)                  count <= '0;
      else if (do_store)              count <= count + 1'b1;
      else if (do_complete || do_flush) count <= '0;
      else if (do_lost)               count <= CntWidth'(1);

      if (do_store) begin
        for (int i = 0; i < BufDepth; i++) begin
          if (count == CntWidth'(i)) buf_data[i] <= data_i;
        end
        if (!group_open) buf_id <= id_i;
      end
      // A lost copy closes the stale group and opens a new one with itself.
      if (do_lost) begin
        buf_data[0] <= data_i;
        buf_id      <= id_i;
      end

      // Counter saturates at LockTimeout so a stalled output still flushes later.
      if (!enable_i || !group_open || accept || do_flush) tmo_cnt <= '0;
      else if (!tmo_expired)                             tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign valid_o          = valid_q;
  assign data_o           = data_q;
  assign id_o             = id_q;
  assign needs_retry_o    = retry_q;
  assign fault_detected_o = fault_q;

endmodule
